isp8_alu_seq: RTL

- Multi-byte arithmetic sequencer for the 8-bit LatticeMico8 ALU (add/sub/cmp path).
- Accepts an NBYTES-wide operation and drives the ALU one byte per cycle, LSB first, chaining carry/borrow through the ALU's carry_flag input.
- Collects the result bytes and final flags, then signals done.
- Sits beside the ALU in the core or in a coprocessor wrapper; the ALU itself stays purely combinational.

---
 rtl/isp8_pkg.sv | 31 +++
 rtl/isp8_alu_seq_ctl.sv | 127 ++++++++++++
 rtl/isp8_alu_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/isp8_pkg.sv
// Shared encodings for the isp8 multi-byte ALU sequencer: op codes, FSM states
// and the ALU instruction words driven while sequencing / idle.
package isp8_pkg;

  typedef enum logic [2:0] {
    ISP8_SEQ_ADD  = 3'b000,
    ISP8_SEQ_ADDC = 3'b001,
    ISP8_SEQ_SUB  = 3'b010,
    ISP8_SEQ_SUBC = 3'b011,
    ISP8_SEQ_CMP  = 3'b100
  } isp8_seq_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } isp8_seq_state_e;

  // All-zero instruction selects the ALU add/sub result path.
  localparam logic [17:0] ISP8_ALU_INSTR_ARITH = 18'h00000;
  localparam logic [17:0] ISP8_ALU_INSTR_IDLE  = 18'h3FFFF;

  function automatic logic isp8_op_legal(input logic [2:0] op);
    return (op <= ISP8_SEQ_CMP);
  endfunction

  function automatic logic isp8_op_is_sub(input logic [2:0] op);
    return (op == ISP8_SEQ_SUB) || (op == ISP8_SEQ_SUBC) || (op == ISP8_SEQ_CMP);
  endfunction

endpackage

// File: rtl/isp8_alu_seq_ctl.sv
// Sequencer control: IDLE/RUN/DONE FSM, byte index and per-byte ALU mode strobes.
// Latches op and cin at launch so the strobe decode is stable for the whole run.
module isp8_alu_seq_ctl
  import isp8_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       cin,
  input  logic       prev_cout,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       launch,
  output logic       last,
  output logic       op_is_cmp,
  output logic [1:0] idx,
  output logic       alu_sub,
  output logic       alu_subc,
  output logic       alu_addc,
  output logic       alu_cmp,
  output logic       alu_carry
);

  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  isp8_seq_state_e state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      op_q, op_d;
  logic            cin_q, cin_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      op_q    <= 3'd0;
      cin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    cin_d   = cin_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (isp8_op_legal(op)) begin
            state_d = RUN;
            idx_d   = 2'd0;
            op_d    = op;
            cin_d   = cin;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign launch    = (state_q == IDLE) && start && isp8_op_legal(op);
  assign last      = busy && (idx_q == LAST_IDX);
  assign op_is_cmp = (op_q == ISP8_SEQ_CMP);
  assign idx       = idx_q;

  // Byte 0 uses the op's own mode; later bytes chain the registered carry/borrow.
  always_comb begin
    alu_sub   = 1'b0;
    alu_subc  = 1'b0;
    alu_addc  = 1'b0;
    alu_cmp   = 1'b0;
    alu_carry = 1'b0;
    if (busy) begin
      if (idx_q == 2'd0) begin
        case (op_q)
          ISP8_SEQ_ADDC: begin
            alu_addc  = 1'b1;
            alu_carry = cin_q;
          end
          ISP8_SEQ_SUB:  alu_sub = 1'b1;
          ISP8_SEQ_SUBC: begin
            alu_subc  = 1'b1;
            alu_carry = cin_q;
          end
          ISP8_SEQ_CMP:  alu_cmp = 1'b1;
          default: ;
        endcase
      end else begin
        if (isp8_op_is_sub(op_q)) begin
          alu_subc = 1'b1;
        end else begin
          alu_addc = 1'b1;
        end
        alu_carry = prev_cout;
      end
    end
  end

endmodule

// File: rtl/isp8_alu_seq.sv
// Multi-byte add/sub/cmp sequencer driving the 8-bit LatticeMico8 ALU LSB first.
// Optional signed-overflow output enabled by defining ISP8_ALU_SEQ_OVF_EN.
module isp8_alu_seq
  import isp8_pkg::*;
#(
  parameter int    NBYTES      = 2,
  parameter string FAMILY_NAME = "XO"
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [8*NBYTES-1:0] opa,
  input  logic [8*NBYTES-1:0] opb,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [8*NBYTES-1:0] result,
  output logic                carry,
  output logic                zero,
  output logic [17:0]         alu_instr,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic                alu_carry,
  output logic                alu_sub,
  output logic                alu_subc,
  output logic                alu_addc,
  output logic                alu_cmp,
  input  logic [7:0]          alu_dout,
  input  logic                alu_cout
`ifdef ISP8_ALU_SEQ_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int W = 8 * NBYTES;

  if (NBYTES < 2 || NBYTES > 4) begin : g_bad_nbytes
    $error("isp8_alu_seq: NBYTES=%0d outside 2..4 (family %s)", NBYTES, FAMILY_NAME);
  end

  logic       launch;
  logic       last;
  logic       op_is_cmp;
  logic [1:0] idx;
  logic       cout_q, cout_d;

  isp8_alu_seq_ctl #(
    .NBYTES(NBYTES)
  ) u_ctl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .cin       (cin),
    .prev_cout (cout_q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .launch    (launch),
    .last      (last),
    .op_is_cmp (op_is_cmp),
    .idx       (idx),
    .alu_sub   (alu_sub),
    .alu_subc  (alu_subc),
    .alu_addc  (alu_addc),
    .alu_cmp   (alu_cmp),
    .alu_carry (alu_carry)
  );

  logic [W-1:0] a_sh_q, a_sh_d;
  logic [W-1:0] b_sh_q, b_sh_d;
  logic [W-1:0] result_q, result_d;
  logic         carry_q, carry_d;
  logic         zero_q, zero_d;
  logic         zacc_q, zacc_d;
  logic         dout_zero;

  assign dout_zero = (alu_dout == 8'h00);

  // Operands shift right one byte per RUN cycle so byte 0 always feeds the ALU.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    zacc_d  = zacc_q;
    if (launch) begin
      a_sh_d = opa;
      b_sh_d = opb;
      cout_d = 1'b0;
      zacc_d = 1'b1;
    end else if (busy) begin
      a_sh_d = a_sh_q >> 8;
      b_sh_d = b_sh_q >> 8;
      cout_d = alu_cout;
      zacc_d = zacc_q & dout_zero;
      if (last) begin
        carry_d = alu_cout;
        zero_d  = zacc_q & dout_zero;
      end
    end
  end

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_res_byte
    assign result_d[gi*8 +: 8] = (busy && !op_is_cmp && (idx == 2'(gi))) ?
                                 alu_dout : result_q[gi*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      zacc_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      zacc_q   <= zacc_d;
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign alu_instr = busy ? ISP8_ALU_INSTR_ARITH : ISP8_ALU_INSTR_IDLE;
  assign alu_a     = busy ? a_sh_q[7:0] : 8'h00;
  assign alu_b     = busy ? b_sh_q[7:0] : 8'h00;

`ifdef ISP8_ALU_SEQ_OVF_EN
  logic ovf_q, ovf_d;

  // On the last byte the ALU is always in a chaining mode, so alu_subc tells sub-class from add-class.
  always_comb begin
    ovf_d = ovf_q;
    if (last) begin
      if (alu_subc) begin
        ovf_d = (alu_a[7] != alu_b[7]) && (alu_dout[7] != alu_a[7]);
      end else begin
        ovf_d = (alu_a[7] == alu_b[7]) && (alu_dout[7] != alu_a[7]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
